// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV32I/RV64I immediate decoder with an OUT register and a one-entry skid register.
// Define IMM_GEN_PERF_EN to add the perf_total / perf_none accept counters.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst_code,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_out,
  output logic [2:0]       fmt,
  output logic [TAG_W-1:0] out_tag
`ifdef IMM_GEN_PERF_EN
  ,
  output logic [31:0]      perf_total,
  output logic [31:0]      perf_none
`endif
);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_FULL = 2'd2} state_t;

  state_t                  state_q;
  logic                    out_valid_q;
  logic                    in_ready_q;
  logic [XLEN-1:0]         imm_q;
  logic [2:0]              fmt_q;
  logic [TAG_W-1:0]        tag_q;
  logic [XLEN-1:0]         skid_imm_q;
  logic [2:0]              skid_fmt_q;
  logic [TAG_W-1:0]        skid_tag_q;

  logic [2:0]              dec_fmt;
  logic signed [31:0]      dec_raw;
  logic [XLEN-1:0]         dec_imm;
  logic                    accept;
  logic                    load_skid;

  // Every immediate fits in 32 signed bits; widening to XLEN is one sign extension.
  always_comb begin
    dec_fmt = FMT_NONE;
    dec_raw = '0;
    case (inst_code[6:0])
      OP_LOAD, OP_JALR: begin
        dec_fmt = FMT_I;
        dec_raw = {{20{inst_code[31]}}, inst_code[31:20]};
      end
      OP_IMM: begin
        if (inst_code[14:12] == 3'b001 || inst_code[14:12] == 3'b101) begin
          dec_fmt = FMT_SHAMT;
          dec_raw = (XLEN == 64) ? {26'd0, inst_code[25:20]} : {27'd0, inst_code[24:20]};
        end else begin
          dec_fmt = FMT_I;
          dec_raw = {{20{inst_code[31]}}, inst_code[31:20]};
        end
      end
      OP_STORE: begin
        dec_fmt = FMT_S;
        dec_raw = {{20{inst_code[31]}}, inst_code[31:25], inst_code[11:7]};
      end
      OP_BRANCH: begin
        dec_fmt = FMT_B;
        dec_raw = {{19{inst_code[31]}}, inst_code[31], inst_code[7], inst_code[30:25],
                   inst_code[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        dec_fmt = FMT_U;
        dec_raw = {inst_code[31:12], 12'd0};
      end
      OP_JAL: begin
        dec_fmt = FMT_J;
        dec_raw = {{11{inst_code[31]}}, inst_code[31], inst_code[19:12], inst_code[20],
                   inst_code[30:21], 1'b0};
      end
      default: begin
        dec_fmt = FMT_NONE;
        dec_raw = '0;
      end
    endcase
  end

  assign dec_imm   = XLEN'(dec_raw);
  assign accept    = in_valid & in_ready_q & ~flush;
  assign load_skid = (state_q == ST_ONE) & accept & ~out_ready;

  // Stage boundary: OUT register and handshake state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      imm_q       <= '0;
      fmt_q       <= FMT_NONE;
      tag_q       <= '0;
    end else if (flush) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            imm_q       <= dec_imm;
            fmt_q       <= dec_fmt;
            tag_q       <= in_tag;
            out_valid_q <= 1'b1;
            state_q     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && out_ready) begin
            imm_q <= dec_imm;
            fmt_q <= dec_fmt;
            tag_q <= in_tag;
          end else if (accept) begin
            in_ready_q <= 1'b0;
            state_q    <= ST_FULL;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            imm_q      <= skid_imm_q;
            fmt_q      <= skid_fmt_q;
            tag_q      <= skid_tag_q;
            in_ready_q <= 1'b1;
            state_q    <= ST_ONE;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  // Stage boundary: skid register, only meaningful while in ST_FULL.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_imm_q <= dec_imm;
      skid_fmt_q <= dec_fmt;
      skid_tag_q <= in_tag;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign imm_out   = imm_q;
  assign fmt       = fmt_q;
  assign out_tag   = tag_q;

`ifdef IMM_GEN_PERF_EN
  logic [31:0] perf_total_q;
  logic [31:0] perf_none_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_total_q <= '0;
      perf_none_q  <= '0;
    end else if (accept) begin
      perf_total_q <= perf_total_q + 32'd1;
      if (dec_fmt == FMT_NONE) perf_none_q <= perf_none_q + 32'd1;
    end
  end

  assign perf_total = perf_total_q;
  assign perf_none  = perf_none_q;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances, scoreboard plus directed checks.
`timescale 1ns/1ps
module tb_imm_gen_pipe;
  localparam int TAG_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, flush;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [31:0]      inst_code, imm_out;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic [2:0]       fmt;
  logic             in_valid64, in_ready64, out_valid64, out_ready64;
  logic [31:0]      inst64;
  logic [TAG_W-1:0] tag64, out_tag64;
  logic [63:0]      imm64;
  logic [2:0]       fmt64;
`ifdef IMM_GEN_PERF_EN
  logic [31:0]      perf_total, perf_none, perf_total64, perf_none64;
`endif

  int errors = 0;
  int checks = 0;
  int pops32 = 0;

  typedef struct packed {
    logic [63:0]      imm;
    logic [2:0]       fmt;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  exp_t e32, e64, prev32;
  bit   stall32 = 0;

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .inst_code(inst_code), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .imm_out(imm_out), .fmt(fmt), .out_tag(out_tag)
`ifdef IMM_GEN_PERF_EN
    , .perf_total(perf_total), .perf_none(perf_none)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid64), .in_ready(in_ready64), .inst_code(inst64), .in_tag(tag64),
    .out_valid(out_valid64), .out_ready(out_ready64), .imm_out(imm64), .fmt(fmt64), .out_tag(out_tag64)
`ifdef IMM_GEN_PERF_EN
    , .perf_total(perf_total64), .perf_none(perf_none64)
`endif
  );

  // Reference decoder written from the ISA field layouts.
  function automatic exp_t ref_dec(input logic [31:0] i, input logic [TAG_W-1:0] t, input bit x64);
    logic signed [63:0] v;
    exp_t e;
    v = '0;
    e.fmt = 3'd0;
    case (i[6:0])
      7'h03, 7'h67: begin e.fmt = 3'd1; v = 64'($signed(i[31:20])); end
      7'h13: begin
        if (i[13:12] == 2'b01) begin
          e.fmt = 3'd6;
          v = x64 ? {58'd0, i[25:20]} : {59'd0, i[24:20]};
        end else begin
          e.fmt = 3'd1; v = 64'($signed(i[31:20]));
        end
      end
      7'h23: begin e.fmt = 3'd2; v = 64'($signed({i[31:25], i[11:7]})); end
      7'h63: begin e.fmt = 3'd3; v = 64'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); end
      7'h37, 7'h17: begin e.fmt = 3'd4; v = 64'($signed({i[31:12], 12'h000})); end
      7'h6F: begin e.fmt = 3'd5; v = 64'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
      default: begin e.fmt = 3'd0; v = '0; end
    endcase
    e.imm = x64 ? v : {32'd0, v[31:0]};
    e.tag = t;
    return e;
  endfunction

  // Scoreboard for the 32-bit instance: push on accept, pop on output transfer, check hold under stall.
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      q32.delete();
      stall32 = 0;
    end else begin
      if (stall32) begin
        checks++;
        if ({out_valid, imm_out, fmt, out_tag} !== {1'b1, prev32.imm[31:0], prev32.fmt, prev32.tag}) begin
          errors++;
          $display("FAIL hold32: got v=%b imm=%h fmt=%0d tag=%h want imm=%h fmt=%0d tag=%h",
                   out_valid, imm_out, fmt, out_tag, prev32.imm[31:0], prev32.fmt, prev32.tag);
        end
      end
      stall32 = out_valid && !out_ready;
      prev32 = {32'd0, imm_out, fmt, out_tag};
      if (out_valid && out_ready) begin
        checks++;
        if (q32.size() == 0) begin
          errors++;
          $display("FAIL sb32_extra: got tag=%h want no output", out_tag);
        end else begin
          e32 = q32.pop_front();
          pops32++;
          if ({imm_out, fmt, out_tag} !== {e32.imm[31:0], e32.fmt, e32.tag}) begin
            errors++;
            $display("FAIL sb32: got imm=%h fmt=%0d tag=%h want imm=%h fmt=%0d tag=%h",
                     imm_out, fmt, out_tag, e32.imm[31:0], e32.fmt, e32.tag);
          end
        end
      end
      if (in_valid && in_ready) q32.push_back(ref_dec(inst_code, in_tag, 1'b0));
    end
  end

  always @(negedge clk) begin
    if (!rst_n || flush) begin
      q64.delete();
    end else begin
      if (out_valid64 && out_ready64) begin
        checks++;
        if (q64.size() == 0) begin
          errors++;
          $display("FAIL sb64_extra: got tag=%h want no output", out_tag64);
        end else begin
          e64 = q64.pop_front();
          if ({imm64, fmt64, out_tag64} !== {e64.imm, e64.fmt, e64.tag}) begin
            errors++;
            $display("FAIL sb64: got imm=%h fmt=%0d tag=%h want imm=%h fmt=%0d tag=%h",
                     imm64, fmt64, out_tag64, e64.imm, e64.fmt, e64.tag);
          end
        end
      end
      if (in_valid64 && in_ready64) q64.push_back(ref_dec(inst64, tag64, 1'b1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0;
    in_valid = 1'b0; inst_code = '0; in_tag = '0; out_ready = 1'b1;
    in_valid64 = 1'b0; inst64 = '0; tag64 = '0; out_ready64 = 1'b1;
    repeat (2) tick();
    checks++;
    if (out_valid !== 1'b0 || out_valid64 !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b/%b want 0/0", out_valid, out_valid64);
    end
    #2 rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got ready=%b valid=%b want 1/0", in_ready, out_valid);
    end
    checks++;
    if (imm_out !== 32'd0 || fmt !== 3'd0 || out_tag !== 8'd0 || imm64 !== 64'd0) begin
      errors++; $display("FAIL reset_data: got imm=%h fmt=%0d tag=%h imm64=%h want zeros", imm_out, fmt, out_tag, imm64);
    end
  endtask

  task automatic test_single(input logic [31:0] inst, input logic [7:0] tag,
                             input logic [31:0] want_imm, input logic [2:0] want_fmt);
    out_ready = 1'b1;
    in_valid = 1'b1; inst_code = inst; in_tag = tag;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, imm_out, fmt, out_tag} !== {1'b1, want_imm, want_fmt, tag}) begin
      errors++;
      $display("FAIL single_%h: got v=%b imm=%h fmt=%0d tag=%h want v=1 imm=%h fmt=%0d tag=%h",
               inst, out_valid, imm_out, fmt, out_tag, want_imm, want_fmt, tag);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] insts[3] = '{32'hFE000EE3, 32'h123452B7, 32'h001000EF};
    logic [31:0] imms[3]  = '{32'hFFFFFFFC, 32'h12345000, 32'h00000800};
    logic [2:0]  fmts[3]  = '{3'd3, 3'd4, 3'd5};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; inst_code = insts[i]; in_tag = 8'h30 + 8'(i);
      tick();
      checks++;
      if ({out_valid, imm_out, fmt, out_tag} !== {1'b1, imms[i], fmts[i], 8'h30 + 8'(i)}) begin
        errors++;
        $display("FAIL b2b_%0d: got v=%b imm=%h fmt=%0d tag=%h want imm=%h fmt=%0d tag=%h",
                 i, out_valid, imm_out, fmt, out_tag, imms[i], fmts[i], 8'h30 + 8'(i));
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    int p0 = pops32;
    out_ready = 1'b0;
    in_valid = 1'b1; inst_code = 32'h00500093; in_tag = 8'hA1;
    tick();
    checks++;
    if (out_tag !== 8'hA1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_first: got tag=%h ready=%b want A1/1", out_tag, in_ready);
    end
    inst_code = 32'hFF810113; in_tag = 8'hA2;
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_full: got ready=%b want 0", in_ready);
    end
    inst_code = 32'h00C0006F; in_tag = 8'hA3;
    repeat (2) tick();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 8'hA1) begin
      errors++; $display("FAIL bp_hold: got ready=%b v=%b tag=%h want 0/1/A1", in_ready, out_valid, out_tag);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_tag !== 8'hA2 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_skid: got tag=%h ready=%b want A2/1", out_tag, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_tag !== 8'hA3 || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_third: got tag=%h v=%b want A3/1", out_tag, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || pops32 - p0 !== 3 || q32.size() !== 0) begin
      errors++; $display("FAIL bp_drain: got v=%b pops=%0d left=%0d want 0/3/0", out_valid, pops32 - p0, q32.size());
    end
  endtask

  task automatic test_flush();
`ifdef IMM_GEN_PERF_EN
    logic [31:0] t0 = perf_total;
`endif
    out_ready = 1'b0;
    in_valid = 1'b1; inst_code = 32'h00100093; in_tag = 8'hF1;
    tick();
    inst_code = 32'h00200093; in_tag = 8'hF2;
    tick();
    inst_code = 32'h00300093; in_tag = 8'hF3; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_full: got v=%b ready=%b want 0/1", out_valid, in_ready);
    end
    in_valid = 1'b1; inst_code = 32'h00400093; in_tag = 8'hF4; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_drop: got v=%b tag=%h want v=0", out_valid, out_tag);
    end
`ifdef IMM_GEN_PERF_EN
    checks++;
    if (perf_total - t0 !== 32'd2) begin
      errors++; $display("FAIL perf_flush: got %0d want 2", perf_total - t0);
    end
`endif
  endtask

  task automatic test_none();
`ifdef IMM_GEN_PERF_EN
    logic [31:0] n0 = perf_none;
`endif
    test_single(32'h002081B3, 8'h51, 32'h00000000, 3'd0);
`ifdef IMM_GEN_PERF_EN
    checks++;
    if (perf_none - n0 !== 32'd1) begin
      errors++; $display("FAIL perf_none: got %0d want 1", perf_none - n0);
    end
`endif
  endtask

  task automatic test_random_stream();
    logic [6:0] ops[10] = '{7'h03, 7'h67, 7'h13, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
    logic [31:0] r;
    int n;
    for (int i = 0; i < 80; i++) begin
      r = $urandom();
      in_valid = ($urandom_range(0, 3) != 0);
      inst_code = {r[31:7], ops[$urandom_range(0, 9)]};
      in_tag = 8'(i);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (q32.size() != 0 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (q32.size() !== 0) begin
      errors++; $display("FAIL rand_drain: got %0d pending want 0", q32.size());
    end
  endtask

  task automatic test_xlen64();
    out_ready64 = 1'b1;
    in_valid64 = 1'b1; inst64 = 32'h80000037; tag64 = 8'h64;
    tick();
    checks++;
    if ({out_valid64, imm64, fmt64, out_tag64} !== {1'b1, 64'hFFFFFFFF80000000, 3'd4, 8'h64}) begin
      errors++; $display("FAIL lui64: got v=%b imm=%h fmt=%0d want imm=ffffffff80000000 fmt=4", out_valid64, imm64, fmt64);
    end
    inst64 = 32'h43F0D093; tag64 = 8'h65;
    tick();
    in_valid64 = 1'b0;
    checks++;
    if (imm64 !== 64'd63 || fmt64 !== 3'd6) begin
      errors++; $display("FAIL shamt64: got imm=%h fmt=%0d want 3f/6", imm64, fmt64);
    end
    out_ready64 = 1'b0; out_ready = 1'b0;
    in_valid64 = 1'b1; inst64 = 32'h00000013; tag64 = 8'h66;
    in_valid = 1'b1; inst_code = 32'h00000013; in_tag = 8'h67;
    tick();
    in_valid64 = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid64 !== 1'b1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL pre_rst: got %b/%b want 1/1", out_valid64, out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid64 !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL async_rst: got %b/%b want 0/0", out_valid64, out_valid);
    end
    tick();
    rst_n = 1'b1; out_ready64 = 1'b1; out_ready = 1'b1;
    repeat (2) tick();
    checks++;
    if (out_valid64 !== 1'b0 || out_valid !== 1'b0 || in_ready64 !== 1'b1) begin
      errors++; $display("FAIL post_rst: got v=%b/%b ready=%b want 0/0/1", out_valid64, out_valid, in_ready64);
    end
  endtask

  initial begin
    test_reset();
    test_single(32'hFFF00093, 8'h11, 32'hFFFFFFFF, 3'd1);
    test_single(32'h4030D093, 8'h12, 32'h00000003, 3'd6);
    test_single(32'h43F0D093, 8'h13, 32'h0000001F, 3'd6);
    test_single(32'hFE512C23, 8'h14, 32'hFFFFFFF8, 3'd2);
    test_none();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_random_stream();
    test_xlen64();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
